// File: rtl/bocks_vram_pkg.sv
// Shared types and default widths for the VRAM arbiter and its line fetcher.
package bocks_vram_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned LB_AW_DEF  = 7;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } fetch_state_t;

   // One host access as presented on the host port.
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } host_cmd_t;

endpackage

// File: rtl/bocks_vram_arbiter_if.sv
// Host access port: valid/ack request with a one-cycle read-data return.
interface bocks_vram_arbiter_if
   import bocks_vram_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, rvalid
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, rvalid
   );

endinterface

// File: rtl/bocks_line_fetch.sv
// Scanline fetch sequencer: walks one line of VRAM into the line buffer.
module bocks_line_fetch
   import bocks_vram_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned LINE_WORDS = 80,
   parameter int unsigned LB_AW      = LB_AW_DEF
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              line_start,
   input  logic [ADDR_W-1:0] line_base,
   input  logic              ovr_clr,
   input  logic              vid_gnt,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              vid_req,
   output logic [ADDR_W-1:0] vid_addr,
   output logic              line_done,
   output logic              line_overrun,
   output logic              lb_we,
   output logic [LB_AW-1:0]  lb_addr,
   output logic [DATA_W-1:0] lb_wdata
);

   localparam logic [LB_AW-1:0] LAST_IDX = LB_AW'(LINE_WORDS - 1);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LB_AW-1:0]  idx_q, idx_d;
   logic              rv_q;
   logic [LB_AW-1:0]  rv_idx_q;
   logic              done_q, done_d;
   logic              ovr_q, ovr_d;

   // Next-state: line sequencing, restart on overrun, done at IDLE entry.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      if (ovr_clr) ovr_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (line_start) begin
               state_d = FETCH;
               base_d  = line_base;
               idx_d   = '0;
            end
         end
         FETCH: begin
            if (vid_gnt) begin
               if (idx_q == LAST_IDX) state_d = DRAIN;
               else idx_d = idx_q + 1'b1;
            end
            // Restart beats completion; the read granted this cycle still lands.
            if (line_start) begin
               state_d = FETCH;
               base_d  = line_base;
               idx_d   = '0;
               ovr_d   = 1'b1;
            end
         end
         DRAIN: begin
            // Last read returns while in DRAIN; leaving now is the line's end.
            if (rv_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            if (line_start) begin
               state_d = FETCH;
               base_d  = line_base;
               idx_d   = '0;
               if (!rv_q) ovr_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers plus the one-deep read-return pipeline.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         idx_q    <= '0;
         rv_q     <= 1'b0;
         rv_idx_q <= '0;
         done_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         idx_q   <= idx_d;
         rv_q    <= vid_gnt;
         if (vid_gnt) rv_idx_q <= idx_q;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign vid_req      = (state_q == FETCH);
   assign vid_addr     = base_q + ADDR_W'(idx_q);
   assign line_done    = done_q;
   assign line_overrun = ovr_q;
   assign lb_we        = rv_q;
   assign lb_addr      = rv_idx_q;
   assign lb_wdata     = rv_q ? ram_rdata : '0;

endmodule

// File: rtl/bocks_vram_arbiter.sv
// Single-port VRAM owner: video fetch has priority, host gets a starvation-bounded share.
module bocks_vram_arbiter
   import bocks_vram_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned LINE_WORDS = 80,
   parameter int unsigned LB_AW      = LB_AW_DEF,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic                    clk_sys,
   input  logic                    reset,
   input  logic                    line_start,
   input  logic [ADDR_W-1:0]       line_base,
   output logic                    line_done,
   output logic                    line_overrun,
   output logic                    lb_we,
   output logic [LB_AW-1:0]        lb_addr,
   output logic [DATA_W-1:0]       lb_wdata,
   bocks_vram_arbiter_if.slave     host,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic                    ram_we,
   output logic [DATA_W-1:0]       ram_wdata,
   input  logic [DATA_W-1:0]       ram_rdata,
   input  logic                    ovr_clr
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

   logic              vid_req;
   logic              vid_gnt;
   logic              host_gnt;
   logic [ADDR_W-1:0] vid_addr;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        starve_q, starve_d;
   logic              hrv_q;

   bocks_line_fetch #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (LINE_WORDS),
      .LB_AW      (LB_AW)
   ) u_fetch (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .line_start   (line_start),
      .line_base    (line_base),
      .ovr_clr      (ovr_clr),
      .vid_gnt      (vid_gnt),
      .ram_rdata    (ram_rdata),
      .vid_req      (vid_req),
      .vid_addr     (vid_addr),
      .line_done    (line_done),
      .line_overrun (line_overrun),
      .lb_we        (lb_we),
      .lb_addr      (lb_addr),
      .lb_wdata     (lb_wdata)
   );

   // Grant and VRAM mux; grants are held off while reset is asserted.
   always_comb begin
      host_gnt  = host.req & ~reset & (~vid_req | (starve_q == STARVE_MAX));
      vid_gnt   = vid_req & ~reset & ~host_gnt;
      ram_we    = host_gnt & host.we;
      ram_wdata = host_gnt ? host.wdata : '0;
      if (host_gnt)     ram_addr = host.addr;
      else if (vid_gnt) ram_addr = vid_addr;
      else              ram_addr = addr_q;
      // Count cycles the waiting host loses to video; any other cycle clears it.
      starve_d = (host.req & vid_gnt) ? starve_q + 4'd1 : 4'd0;
   end

   // Last issued address, starve count and host read-return flag.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         starve_q <= '0;
         hrv_q    <= 1'b0;
      end else begin
         addr_q   <= ram_addr;
         starve_q <= starve_d;
         hrv_q    <= host_gnt & ~host.we;
      end
   end

   assign host.ack    = host_gnt;
   assign host.rvalid = hrv_q;
   assign host.rdata  = hrv_q ? ram_rdata : '0;

endmodule

// File: tb/tb_bocks_vram_arbiter.sv
// Bench for bocks_vram_arbiter: RAM model, line-buffer/read-data scoreboards,
// a host vector table and hand sequences for fetch, starvation, wrap, overrun and reset.
module tb_bocks_vram_arbiter;
   import bocks_vram_pkg::*;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned LB_AW  = 7;

   logic              clk_sys = 1'b0;
   logic              reset;
   logic              line_start;
   logic [15:0]       line_base;
   logic              ovr_clr;
   logic              line_done;
   logic              line_overrun;
   logic              lb_we;
   logic [6:0]        lb_addr;
   logic [15:0]       lb_wdata;
   logic [15:0]       ram_addr;
   logic              ram_we;
   logic [15:0]       ram_wdata;
   logic [15:0]       ram_rdata;

   bocks_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

   bocks_vram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .LINE_WORDS (80),
      .LB_AW      (LB_AW),
      .STARVE_LIM (4)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .line_start   (line_start),
      .line_base    (line_base),
      .line_done    (line_done),
      .line_overrun (line_overrun),
      .lb_we        (lb_we),
      .lb_addr      (lb_addr),
      .lb_wdata     (lb_wdata),
      .host         (host),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .ovr_clr      (ovr_clr)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic [6:0]  idx;
      logic [15:0] addr;
      logic [15:0] data;
   } lb_exp_t;

   typedef struct {
      logic [15:0] data;
      int          due;
   } rd_exp_t;

   typedef struct {
      logic        req;
      host_cmd_t   cmd;
      logic        exp_ack;
      logic [15:0] exp_rdata;
   } host_vec_t;

   lb_exp_t     lb_q[$];
   rd_exp_t     rd_q[$];
   int          done_times[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] prev_addr = '0;
   logic [15:0] mem [0:65535];
   lb_exp_t     mon_lb;
   rd_exp_t     mon_rd;

   function automatic logic [15:0] model_word(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Synchronous single-port RAM, one-cycle read latency.
   initial for (int a = 0; a < 65536; a++) mem[a] = model_word(16'(a));
   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   always @(posedge clk_sys) cyc <= cyc + 1;

   // Output monitor: pops scoreboards when the DUT produces data.
   always @(negedge clk_sys) begin
      if (lb_we) begin
         if (lb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lb_we unexpected: lb_addr %0h lb_wdata %0h", lb_addr, lb_wdata);
         end else begin
            mon_lb = lb_q.pop_front();
            chk("lb_addr", 32'(lb_addr), 32'(mon_lb.idx));
            chk("lb_wdata", 32'(lb_wdata), 32'(mon_lb.data));
            chk("fetch ram_addr", 32'(prev_addr), 32'(mon_lb.addr));
         end
      end
      if (host.rvalid) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL host_rvalid unexpected: rdata %0h", host.rdata);
         end else begin
            mon_rd = rd_q.pop_front();
            chk("host_rdata", 32'(host.rdata), 32'(mon_rd.data));
            chk("rvalid latency", cyc, mon_rd.due);
         end
      end
      if (line_done) done_times.push_back(cyc);
      prev_addr = ram_addr;
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // Pulse line_start for one cycle and queue the expected first n line-buffer words.
   task automatic start_line(input logic [15:0] base, input int n, output int t0);
      line_start = 1'b1;
      line_base  = base;
      t0         = cyc;
      for (int k = 0; k < n; k++)
         lb_q.push_back('{idx: 7'(k), addr: base + 16'(k), data: model_word(base + 16'(k))});
      step();
      line_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int n = 0;
      while (done_times.size() < target && n < budget) begin
         step();
         n++;
      end
      if (done_times.size() < target) begin
         checks++;
         errors++;
         $display("FAIL %s: line_done count %0d required %0d", name, done_times.size(), target);
      end
   endtask

   function automatic host_vec_t mk(input logic req, input logic we, input logic [15:0] addr,
                                     input logic [15:0] wdata, input logic ack,
                                     input logic [15:0] rdata);
      host_vec_t v;
      v.req       = req;
      v.cmd.we    = we;
      v.cmd.addr  = addr;
      v.cmd.wdata = wdata;
      v.exp_ack   = ack;
      v.exp_rdata = rdata;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      host_vec_t vec[6];
      int        t0, t1, nd, acks;

      vec[0] = mk(1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b1, 16'h0000);
      vec[1] = mk(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b1, 16'hBEEF);
      vec[2] = mk(1'b1, 1'b1, 16'h7FFF, 16'h0F0F, 1'b1, 16'h0000);
      vec[3] = mk(1'b1, 1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h0F0F);
      vec[4] = mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h5A58);
      vec[5] = mk(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b0, 16'h0000);

      // Reset state, with a host request pending to show ack is held off.
      reset      = 1'b1;
      line_start = 1'b0;
      line_base  = 16'h0000;
      ovr_clr    = 1'b0;
      host.req   = 1'b1;
      host.we    = 1'b1;
      host.addr  = 16'h0055;
      host.wdata = 16'hAAAA;
      #12;
      chk("reset line_done", 32'(line_done), 0);
      chk("reset line_overrun", 32'(line_overrun), 0);
      chk("reset lb_we", 32'(lb_we), 0);
      chk("reset lb_addr", 32'(lb_addr), 0);
      chk("reset lb_wdata", 32'(lb_wdata), 0);
      chk("reset host_ack", 32'(host.ack), 0);
      chk("reset host_rvalid", 32'(host.rvalid), 0);
      chk("reset host_rdata", 32'(host.rdata), 0);
      chk("reset ram_we", 32'(ram_we), 0);
      chk("reset ram_addr", 32'(ram_addr), 0);
      step();
      host.req = 1'b0;
      reset    = 1'b0;
      step();

      // Basic fetch, then a second line_start landing in the DRAIN cycle.
      start_line(16'h0100, 80, t0);
      @(negedge clk_sys);
      chk("t1 first ram_addr", 32'(ram_addr), 32'h0100);
      repeat (80) step();
      start_line(16'h0400, 80, t1);
      wait_done(2, 200, "t1 done");
      if (done_times.size() >= 2) begin
         chk("t1 done latency", done_times[0] - t0, 82);
         chk("drain restart done latency", done_times[1] - t1, 82);
      end
      chk("drain restart no overrun", 32'(line_overrun), 0);
      chk("t1 lb words drained", lb_q.size(), 0);

      // Host-only table, back-to-back requests.
      for (int i = 0; i < 6; i++) begin
         host.req   = vec[i].req;
         host.we    = vec[i].cmd.we;
         host.addr  = vec[i].cmd.addr;
         host.wdata = vec[i].cmd.wdata;
         @(negedge clk_sys);
         chk($sformatf("host ack vec%0d", i), 32'(host.ack), 32'(vec[i].exp_ack));
         chk($sformatf("ram_we vec%0d", i), 32'(ram_we), 32'(vec[i].req & vec[i].cmd.we));
         if (vec[i].exp_ack && !vec[i].cmd.we)
            rd_q.push_back('{data: vec[i].exp_rdata, due: cyc + 1});
         step();
      end
      host.req = 1'b0;
      step();
      step();
      chk("host reads drained", rd_q.size(), 0);

      // Starvation: host writes held through a whole fetch.
      host.req   = 1'b1;
      host.we    = 1'b1;
      host.addr  = 16'h8000;
      host.wdata = 16'h1111;
      step();
      step();
      nd   = done_times.size();
      acks = 0;
      start_line(16'h0300, 80, t0);
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk_sys);
         chk($sformatf("starve ack c%0d", c), 32'(host.ack), 32'(c % 5 == 0));
         if (host.ack) acks++;
         step();
      end
      host.req = 1'b0;
      wait_done(nd + 1, 50, "starve done");
      if (done_times.size() == nd + 1) chk("starve done latency", done_times[nd] - t0, 101);
      chk("starve host acks", acks, 20);
      chk("starve lb words drained", lb_q.size(), 0);

      // Address wrap at the top of VRAM.
      step();
      nd = done_times.size();
      start_line(16'hFFF0, 80, t0);
      wait_done(nd + 1, 200, "wrap done");
      if (done_times.size() == nd + 1) chk("wrap done latency", done_times[nd] - t0, 82);
      chk("wrap lb words drained", lb_q.size(), 0);

      // Overrun at idx 30, with ovr_clr in the same cycle; overrun must win.
      step();
      nd = done_times.size();
      start_line(16'h0500, 31, t0);
      repeat (30) step();
      ovr_clr = 1'b1;
      start_line(16'h2000, 80, t1);
      ovr_clr = 1'b0;
      chk("overrun set", 32'(line_overrun), 1);
      wait_done(nd + 1, 200, "overrun done");
      repeat (10) step();
      chk("overrun single line_done", done_times.size(), nd + 1);
      if (done_times.size() == nd + 1) chk("overrun done latency", done_times[nd] - t1, 82);
      chk("overrun held", 32'(line_overrun), 1);
      ovr_clr = 1'b1;
      step();
      ovr_clr = 1'b0;
      chk("overrun cleared", 32'(line_overrun), 0);
      chk("overrun lb words drained", lb_q.size(), 0);

      // Asynchronous reset in the middle of a fetch.
      nd = done_times.size();
      start_line(16'h0600, 80, t0);
      repeat (20) step();
      #2;
      reset    = 1'b1;
      host.req = 1'b1;
      host.we  = 1'b1;
      #1;
      chk("midreset lb_we", 32'(lb_we), 0);
      chk("midreset lb_addr", 32'(lb_addr), 0);
      chk("midreset lb_wdata", 32'(lb_wdata), 0);
      chk("midreset ram_addr", 32'(ram_addr), 0);
      chk("midreset ram_we", 32'(ram_we), 0);
      chk("midreset host_ack", 32'(host.ack), 0);
      chk("midreset line_done", 32'(line_done), 0);
      lb_q.delete();
      repeat (3) step();
      host.req = 1'b0;
      reset    = 1'b0;
      repeat (100) step();
      chk("midreset no line_done", done_times.size(), nd);
      start_line(16'h0700, 80, t0);
      wait_done(nd + 1, 200, "post-reset done");
      if (done_times.size() == nd + 1) chk("post-reset done latency", done_times[nd] - t0, 82);
      chk("post-reset lb words drained", lb_q.size(), 0);
      chk("final host reads drained", rd_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
